// File: rtl/led_scanner_if.sv
// rtl/led_scanner_if.sv - control and display bundle between board switches and the LED scanner
//
// Purpose:
//   Groups the scanner's user controls and display outputs so the top level
//   can pass them as one port.
//
// Signals:
//   speed  [1:0]           sweep speed select (00 slowest, 01 mid, 1x fastest)
//   mode   [1:0]           00 bounce, 01 wrap up, 10 wrap down, 11 bar
//   pause                  1 freezes position and direction
//   LEDR   [NUM_LEDS-1:0]  registered LED drive
//   pos    [POS_W-1:0]     registered head index
//   step                   one-cycle pulse when pos takes a new value
//
// Modports:
//   master  drives the controls and observes the display (switches / testbench)
//   slave   the scanner itself
interface led_scanner_if #(
  parameter int NUM_LEDS = 10
);
  localparam int POS_W = $clog2(NUM_LEDS);

  logic [1:0]          speed;
  logic [1:0]          mode;
  logic                pause;
  logic [NUM_LEDS-1:0] LEDR;
  logic [POS_W-1:0]    pos;
  logic                step;

  modport master (
    output speed,
    output mode,
    output pause,
    input  LEDR,
    input  pos,
    input  step
  );

  modport slave (
    input  speed,
    input  mode,
    input  pause,
    output LEDR,
    output pos,
    output step
  );
endinterface

// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - moving-light LED scanner with speed, sweep modes, pause and dimmed trail
//
// Purpose:
//   Moves a single lit head across NUM_LEDS outputs. A free-running prescaler
//   produces a clock-enable tick whose period is selected by speed; on each
//   tick (unless paused) the head advances according to mode. In the non-bar
//   modes the previous head position glows at 25 % duty as a trail.
//
// Parameters:
//   NUM_LEDS         number of LED outputs (2..32)
//   DIV_POW_FASTEST  tick period exponent at the fastest speed
//   DIV_POW_SLOWEST  tick period exponent at the slowest speed (> fastest, >= 2)
//   TAIL_EN          1 shows the dimmed trail, 0 hides it
//
// Ports:
//   CLOCK_50  sole clock, rising edge
//   RESET_N   asynchronous active-low reset
//   sc        led_scanner_if.slave: speed/mode/pause in, LEDR/pos/step out
module led_scanner #(
  parameter int NUM_LEDS        = 10,
  parameter int DIV_POW_FASTEST = 10,
  parameter int DIV_POW_SLOWEST = 26,
  parameter bit TAIL_EN         = 1'b1
) (
  input  logic           CLOCK_50,
  input  logic           RESET_N,
  led_scanner_if.slave   sc
);

  localparam int POS_W       = $clog2(NUM_LEDS);
  localparam int PRE_W       = DIV_POW_SLOWEST;
  localparam int DIV_POW_MID = (DIV_POW_FASTEST + DIV_POW_SLOWEST) / 2;

  localparam logic [POS_W-1:0] POS_MAX    = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_MAX_M1 = POS_W'(NUM_LEDS - 2);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

  // Masks selecting the low E prescaler bits for each speed setting.
  localparam logic [PRE_W-1:0] MASK_SLOW = {PRE_W{1'b1}};
  localparam logic [PRE_W-1:0] MASK_MID  = {PRE_W{1'b1}} >> (PRE_W - DIV_POW_MID);
  localparam logic [PRE_W-1:0] MASK_FAST = {PRE_W{1'b1}} >> (PRE_W - DIV_POW_FASTEST);

  localparam logic [1:0] SPEED_SLOW = 2'b00;
  localparam logic [1:0] SPEED_MID  = 2'b01;

  localparam logic [1:0] MODE_BOUNCE    = 2'b00;
  localparam logic [1:0] MODE_WRAP_UP   = 2'b01;
  localparam logic [1:0] MODE_WRAP_DOWN = 2'b10;
  localparam logic [1:0] MODE_BAR       = 2'b11;

  localparam logic [NUM_LEDS-1:0] LEDR_RESET = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  // Registered state
  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [POS_W-1:0]    prev_q, prev_d;
  logic                dir_q, dir_d;
  logic                step_q, step_d;
  logic [NUM_LEDS-1:0] ledr_q, ledr_d;

  // Combinational helpers
  logic [PRE_W-1:0]    tick_mask;
  logic                tick;
  logic                advance;
  logic                tail_on;

  // ---------------------------------------------------------------------------
  // Prescaler and tick. The counter never pauses and is not disturbed by
  // speed changes; a speed change simply moves which low bits must be all
  // ones, so the first tick after a change may come early.
  // ---------------------------------------------------------------------------
  always_comb begin
    prescaler_d = prescaler_q + PRE_W'(1);

    case (sc.speed)
      SPEED_SLOW: tick_mask = MASK_SLOW;
      SPEED_MID:  tick_mask = MASK_MID;
      default:    tick_mask = MASK_FAST;
    endcase

    // Bits outside the mask are forced high so only the low E bits decide.
    tick    = &(prescaler_q | ~tick_mask);
    advance = tick & ~sc.pause;
  end

  // ---------------------------------------------------------------------------
  // Head movement. Mode is evaluated at each advance against the current
  // pos/dir, so switching modes mid-sweep continues from where the head is.
  // Only the wrap modes overwrite dir.
  // ---------------------------------------------------------------------------
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    prev_d = prev_q;
    step_d = 1'b0;

    if (advance) begin
      step_d = 1'b1;
      prev_d = pos_q;

      case (sc.mode)
        MODE_WRAP_UP: begin
          dir_d = 1'b1;
          pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
        end

        MODE_WRAP_DOWN: begin
          dir_d = 1'b0;
          pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
        end

        default: begin
          // Bounce and bar: reflect at the ends in the same advance, so the
          // end LED is lit for exactly one tick.
          if (dir_q) begin
            if (pos_q == POS_MAX) begin
              dir_d = 1'b0;
              pos_d = POS_MAX_M1;
            end else begin
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = 1'b1;
              pos_d = POS_ONE;
            end else begin
              pos_d = pos_q - POS_ONE;
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // LED pattern from the registered state, registered once more. The trail
  // uses prescaler bits [1:0] for its 1-in-4 duty; before the first advance
  // prev equals pos, so no trail is drawn.
  // ---------------------------------------------------------------------------
  always_comb begin
    tail_on = TAIL_EN && (prev_q != pos_q) && (prescaler_q[1:0] == 2'b00);
    ledr_d  = '0;

    for (int i = 0; i < NUM_LEDS; i++) begin
      if (sc.mode == MODE_BAR) begin
        ledr_d[i] = (i <= int'(pos_q));
      end else begin
        ledr_d[i] = (POS_W'(i) == pos_q) || (tail_on && (POS_W'(i) == prev_q));
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      prescaler_q <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b1;
      prev_q      <= '0;
      step_q      <= 1'b0;
      ledr_q      <= LEDR_RESET;
    end else begin
      prescaler_q <= prescaler_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      prev_q      <= prev_d;
      step_q      <= step_d;
      ledr_q      <= ledr_d;
    end
  end

  assign sc.LEDR = ledr_q;
  assign sc.pos  = pos_q;
  assign sc.step = step_q;

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - scoreboard testbench for led_scanner
module tb_led_scanner;

  localparam int N   = 4;
  localparam int F   = 2;
  localparam int S   = 6;
  localparam int MID = (F + S) / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  led_scanner_if #(.NUM_LEDS(N)) bus ();
  led_scanner_if #(.NUM_LEDS(N)) bus_nt ();

  assign bus_nt.speed = bus.speed;
  assign bus_nt.mode  = bus.mode;
  assign bus_nt.pause = bus.pause;

  led_scanner #(
    .NUM_LEDS(N), .DIV_POW_FASTEST(F), .DIV_POW_SLOWEST(S), .TAIL_EN(1'b1)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .sc(bus.slave)
  );

  led_scanner #(
    .NUM_LEDS(N), .DIV_POW_FASTEST(F), .DIV_POW_SLOWEST(S), .TAIL_EN(1'b0)
  ) dut_nt (
    .CLOCK_50(clk), .RESET_N(rst_n), .sc(bus_nt.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt;
  bit done = 1'b0;

  // Reference state: head, direction (1 = up), previous head.
  int m_pos, m_dir, m_prev;

  typedef struct { int edge_no; int pos; } step_t;
  typedef struct { int edge_no; int led; int led_nt; } led_t;
  step_t step_q[$];
  led_t  led_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t edge %0d: got %0d expected %0d", name, $time, edge_cnt, act, exp);
    end
  endtask

  function automatic int period_exp(input logic [1:0] sp);
    if (sp == 2'b00)      return S;
    else if (sp == 2'b01) return MID;
    else                  return F;
  endfunction

  function automatic int led_pattern(input int md, input int p, input int pv, input int pre_lo, input bit tail);
    int v;
    if (md == 3) return (2 << p) - 1;
    v = 1 << p;
    if (tail && pv != p && pre_lo == 0) v |= (1 << pv);
    return v;
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_dir  = 1;
    m_prev = 0;
    step_q.delete();
    led_q.delete();
  endtask

  // Bounce is modelled as a phase around a ring of 2N-2 positions:
  // phases 0..N-1 go up, N..2N-2 come down.
  task automatic model_advance(input int md);
    int ph;
    case (md)
      1: begin m_prev = m_pos; m_pos = (m_pos + 1) % N;     m_dir = 1; end
      2: begin m_prev = m_pos; m_pos = (m_pos + N - 1) % N; m_dir = 0; end
      default: begin
        ph = m_dir ? m_pos : (2 * N - 2 - m_pos);
        ph = (ph % (2 * N - 2)) + 1;
        m_prev = m_pos;
        m_pos  = (ph <= N - 1) ? ph : (2 * N - 2 - ph);
        m_dir  = (ph <= N - 1) ? 1 : 0;
      end
    endcase
  endtask

  // Called 1 time unit after edge k: predicts LEDR after edge k from the state
  // held before the edge, then applies any advance happening at edge k.
  task automatic model_edge();
    int k;
    led_t l;
    step_t s;
    k = edge_cnt;
    l.edge_no = k;
    l.led    = led_pattern(int'(bus.mode), m_pos, m_prev, (k - 1) % 4, 1'b1);
    l.led_nt = led_pattern(int'(bus.mode), m_pos, m_prev, (k - 1) % 4, 1'b0);
    led_q.push_back(l);
    if ((k % (1 << period_exp(bus.speed))) == 0 && !bus.pause) begin
      model_advance(int'(bus.mode));
      s.edge_no = k;
      s.pos     = m_pos;
      step_q.push_back(s);
    end
  endtask

  task automatic run(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk);
      #1;
      model_edge();
      @(negedge clk);
      if (rnd) begin
        if ($urandom_range(0, 15) == 0) bus.speed = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) bus.mode  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0)  bus.pause = ~bus.pause;
      end
    end
  endtask

  // Reset asserted mid-way through the low clock phase, checked before any edge.
  task automatic mid_reset(input logic [1:0] md_after);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_pos_async",     int'(bus.pos),     0);
    check("reset_step_async",    int'(bus.step),    0);
    check("reset_ledr_async",    int'(bus.LEDR),    1);
    check("reset_ledr_nt_async", int'(bus_nt.LEDR), 1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.mode = md_after;
    rst_n    = 1'b1;
  endtask

  // Monitor: runs after the model on every edge and pops what it predicted.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && edge_cnt > 0 && !done) begin
        while (step_q.size() > 0 && step_q[0].edge_no < edge_cnt) begin
          check("step_missing", 0, 1);
          void'(step_q.pop_front());
        end
        if (bus.step) begin
          if (step_q.size() > 0 && step_q[0].edge_no == edge_cnt) begin
            check("pos_on_step",    int'(bus.pos),    step_q[0].pos);
            check("pos_nt_on_step", int'(bus_nt.pos), step_q[0].pos);
            void'(step_q.pop_front());
          end else begin
            check("step_unexpected", 1, 0);
          end
        end
        if (led_q.size() > 0 && led_q[0].edge_no == edge_cnt) begin
          check("ledr",    int'(bus.LEDR),    led_q[0].led);
          check("ledr_nt", int'(bus_nt.LEDR), led_q[0].led_nt);
          void'(led_q.pop_front());
        end else begin
          check("ledr_prediction_missing", 0, 1);
        end
      end
    end
  end

  initial begin
    bus.speed = 2'b10;
    bus.mode  = 2'b00;
    bus.pause = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_pos",     int'(bus.pos),     0);
    check("reset_step",    int'(bus.step),    0);
    check("reset_ledr",    int'(bus.LEDR),    1);
    check("reset_ledr_nt", int'(bus_nt.LEDR), 1);
    rst_n = 1'b1;

    // Bounce at fastest speed from reset.
    run(40, 1'b0);
    // Wrap up, wrap down, then back to bounce from the middle of a wrap.
    bus.mode = 2'b01; run(16, 1'b0);
    bus.mode = 2'b10; run(16, 1'b0);
    bus.mode = 2'b01; run(10, 1'b0);
    bus.mode = 2'b00; run(16, 1'b0);
    // Bar mode.
    bus.mode = 2'b11; run(24, 1'b0);
    // Pause across several ticks, then slow and mid speeds.
    bus.mode = 2'b00; bus.pause = 1'b1; run(12, 1'b0);
    bus.pause = 1'b0;
    bus.speed = 2'b00; run(140, 1'b0);
    bus.speed = 2'b01; run(48, 1'b0);
    // Randomised speed/mode/pause.
    run(3000, 1'b1);

    // Wrap down from reset puts the head at 3 with dir down, then reset mid-sweep.
    bus.speed = 2'b10;
    bus.pause = 1'b0;
    mid_reset(2'b10);
    run(6, 1'b0);
    check("pre_reset_pos", int'(bus.pos), 3);
    mid_reset(2'b00);
    run(24, 1'b0);

    done = 1'b1;
    check("step_queue_drained", step_q.size(), 0);
    check("led_queue_drained",  led_q.size(),  0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
